// File: rtl/labfinalsoc_pio_pkg.sv
// Shared constants and types for the pulse-capable output PIO.
// Holds the register word offsets, the STATUS bit positions and the pulse FSM states.
package labfinalsoc_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLR       = 3'd2;
    localparam logic [2:0] ADDR_PULSE     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_IRQ_EN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } pulse_state_t;

endpackage

// File: rtl/labfinalsoc_pio_pulse_timer.sv
// Pulse-length down-counter and IDLE/BUSY FSM.
// A load starts or retriggers the timer; expire fires on the cycle the pulse ends.
module labfinalsoc_pio_pulse_timer
    import labfinalsoc_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             expire
);

    pulse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;

    // A programmed length of 0 behaves exactly like a length of 1.
    assign load_val = (len == '0) ? '0 : len - CNT_W'(1);
    assign busy     = (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = BUSY;
                    cnt_d   = load_val;
                end
            end
            BUSY: begin
                // A retrigger on the final cycle takes priority over expiry.
                if (load) begin
                    cnt_d = load_val;
                end else if (cnt_q == '0) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/labfinalsoc_pio_pulse.sv
// Avalon-MM output PIO with direct, set, clear and timed-pulse write modes.
// out_port is the OR of the static data bits and the currently pulsing bits.
module labfinalsoc_pio_pulse
    import labfinalsoc_pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               CNT_W           = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter logic [CNT_W-1:0] PULSE_LEN_RESET = CNT_W'(1000)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd_mask;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] pulse_mask;
    logic [CNT_W-1:0] pulse_len;
    logic             done;
    logic             irq_en;
    logic             busy;
    logic             expire;
    logic             pulse_load;
    logic             unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd_mask          = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;

    // An all-zero pulse write only matters as a retrigger while a pulse is running.
    assign pulse_load = wr && (address == ADDR_PULSE) && (busy || (wd_mask != '0));

    labfinalsoc_pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pulse_load),
        .len     (pulse_len),
        .busy    (busy),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out   <= RESET_VALUE;
            pulse_mask <= '0;
            pulse_len  <= PULSE_LEN_RESET;
            done       <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:      data_out  <= wd_mask;
                    ADDR_SET:       data_out  <= data_out | wd_mask;
                    ADDR_CLR:       data_out  <= data_out & ~wd_mask;
                    ADDR_PULSE_LEN: pulse_len <= writedata[CNT_W-1:0];
                    ADDR_STATUS: begin
                        irq_en <= writedata[STAT_IRQ_EN];
                        if (writedata[STAT_DONE]) begin
                            done <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (pulse_load) begin
                pulse_mask <= pulse_mask | wd_mask;
            end else if (expire) begin
                pulse_mask <= '0;
            end
            // Placed after the clear so a coinciding expiry leaves done set.
            if (expire) begin
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'(data_out);
            ADDR_PULSE:     readdata = 32'(pulse_mask);
            ADDR_PULSE_LEN: readdata = 32'(pulse_len);
            ADDR_STATUS: begin
                readdata[STAT_BUSY]   = busy;
                readdata[STAT_DONE]   = done;
                readdata[STAT_IRQ_EN] = irq_en;
            end
            default: readdata = '0;
        endcase
    end

    assign out_port = data_out | pulse_mask;
    assign irq      = done & irq_en;

endmodule
